// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU slice: latches operands, streams bit pairs LSB first,
// recirculates the slice carry, and collects result bits into a shift register.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] res_next;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {slice_result, res_sh[WIDTH-1:1]};

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register, including the shift registers, is cleared by reset so
  // an aborted operation leaves no stale operand, carry or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      op_q   <= op;
      res_sh <= '0;
      cnt    <= '0;
      // SUB forms A + ~B + 1: the slice inverts B, the +1 enters as the initial carry.
      carry  <= (op == 2'b11);
    end else if (state == RUN) begin
      res_sh <= res_next;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= slice_cout;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        result <= res_next;
        // At the MSB, carry is the carry into it; XOR with carry out gives signed overflow.
        cout   <= op_q[1] & slice_cout;
        ovf    <= op_q[1] & (carry ^ slice_cout);
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign slice_a   = busy & a_sh[0];
  assign slice_b   = busy & b_sh[0];
  assign slice_cin = busy & carry;
  assign slice_op  = op_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: a behavioural 1-bit slice is attached, and a
// timeline/arithmetic model predicts the handshake and final values every cycle.
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] result;
  logic             slice_a, slice_b, slice_cin;
  logic [1:0]       slice_op;
  logic             slice_result, slice_cout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice: AND, OR, ADD, SUB (inverts B itself).
  logic slice_bb;
  always_comb begin
    slice_bb     = slice_op[0] ? ~slice_b : slice_b;
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_op)
      2'b00: slice_result = slice_a & slice_b;
      2'b01: slice_result = slice_a | slice_b;
      default: begin
        slice_result = slice_a ^ slice_bb ^ slice_cin;
        slice_cout   = (slice_a & slice_bb) | (slice_a & slice_cin) | (slice_bb & slice_cin);
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } outcome_t;

  function automatic outcome_t compute(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y);
    outcome_t r;
    logic [WIDTH:0] s;
    r.c = 1'b0;
    r.v = 1'b0;
    case (o)
      2'b00: r.res = x & y;
      2'b01: r.res = x | y;
      2'b10: begin
        s     = {1'b0, x} + {1'b0, y};
        r.res = s[WIDTH-1:0];
        r.c   = s[WIDTH];
        r.v   = (x[WIDTH-1] == y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
      default: begin
        s     = {1'b0, x} + {1'b0, ~y} + 1;
        r.res = s[WIDTH-1:0];
        r.c   = s[WIDTH];
        r.v   = (x[WIDTH-1] != y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
    endcase
    return r;
  endfunction

  // Model: k counts edges since the accepting edge (-1 when idle).
  int               k = -1;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [1:0]       m_op = 2'b00;
  outcome_t         m_pend;
  logic [WIDTH-1:0] m_res = '0;
  logic             m_c = 1'b0, m_v = 1'b0;

  always @(negedge rst_n) begin
    k = -1; m_a = '0; m_b = '0; m_op = 2'b00;
    m_res = '0; m_c = 1'b0; m_v = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (k < 0) begin
        if (start) begin
          k = 0; m_a = a; m_b = b; m_op = op;
          m_pend = compute(op, a, b);
        end
      end else begin
        k++;
        if (k == WIDTH) begin
          m_res = m_pend.res; m_c = m_pend.c; m_v = m_pend.v;
        end else if (k == WIDTH + 1) begin
          k = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_busy;
    e_busy = (k >= 0) && (k < WIDTH);
    check("busy", busy, e_busy);
    check("done", done, k == WIDTH);
    check("result", result, m_res);
    check("cout", cout, m_c);
    check("ovf", ovf, m_v);
    check("slice_op", slice_op, m_op);
    check("slice_a", slice_a, e_busy ? m_a[k] : 1'b0);
    check("slice_b", slice_b, e_busy ? m_b[k] : 1'b0);
  end

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [WIDTH-1:0] er, input logic ec, input logic ev);
    int  cyc = 0, bcnt = 0;
    bit  seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1'b1);
    check("latency", cyc, WIDTH + 1);
    check("busy_cycles", bcnt, WIDTH);
    check("lit_result", result, er);
    check("lit_cout", cout, ec);
    check("lit_ovf", ovf, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b10, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_op(2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op(2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op(2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
    run_op(2'b11, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0);
    run_op(2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
    run_op(2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start held through RUN/DONE with new operands: no re-latch, second op after DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h02;
    @(negedge clk);
    op = 2'b01; a = 8'hAA; b = 8'h55;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b_first_done", seen, 1'b1);
    check("b2b_first_result", result, 8'h03);
    seen = 0; cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("b2b_second_done", seen, 1'b1);
    check("b2b_spacing", cyc, WIDTH + 2);
    check("b2b_second_result", result, 8'hFF);
    check("b2b_second_cout", cout, 1'b0);

    // Reset in the middle of an ADD, after bit 3 has been processed.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h5A; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_done", done, 1'b0);
    check("ar_result", result, 8'h00);
    check("ar_cout", cout, 1'b0);
    check("ar_ovf", ovf, 1'b0);
    check("ar_slice", {slice_a, slice_b, slice_cin, slice_op}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b10, 8'h22, 8'h11, 8'h33, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
